// File: rtl/sound_cmd_mailbox.sv
// Main-CPU <-> sound-CPU mailbox: command FIFO with one NMI per queued command,
// a single response latch, and the SNDRST_b power-on / on-demand reset sequencer.
module sound_cmd_mailbox #(
  parameter int DEPTH      = 4,
  parameter int NMI_WIDTH  = 8,
  parameter int RST_CYCLES = 16
) (
  input  logic       phi0,
  input  logic       rst_b,
  input  logic       main_wr,
  input  logic [7:0] main_din,
  input  logic       main_rd,
  output logic [7:0] main_dout,
  input  logic       main_clr,
  input  logic       main_snd_rst,
  output logic [3:0] main_status,
  input  logic       snd_cmd_rd,
  output logic [7:0] snd_cmd_dout,
  input  logic       snd_rsp_wr,
  input  logic [7:0] snd_rsp_din,
  output logic [1:0] snd_status,
  output logic       SNDNMI_b,
  output logic       SNDRST_b
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(NMI_WIDTH);
  localparam int RW = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {NMI_IDLE, NMI_ASSERT, NMI_WAIT} nmi_state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rsp_q, rsp_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          cmd_ovf_q, cmd_ovf_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  nmi_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ack_q, ack_d;
  logic          nmi_b_q, nmi_b_d;
  logic          sndrst_b_q, sndrst_b_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;

  logic run, empty, full, pop, push, rsp_wr, cmd_ovf_evt, rsp_ovf_evt;

  // Sound side is frozen while the 6502 is held in reset.
  assign run         = sndrst_b_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  assign pop         = run && snd_cmd_rd && !empty;
  assign push        = run && main_wr && (!full || pop);
  assign cmd_ovf_evt = run && main_wr && full && !pop;
  assign rsp_wr      = run && snd_rsp_wr;
  assign rsp_ovf_evt = rsp_wr && rsp_valid_q && !main_rd;

  // NOTE: storage has no reset; contents are only visible through count/pointers,
  // which are reset, so clearing the array would only add reset fan-out.
  always_ff @(posedge phi0) begin
    if (push) mem_q[wr_ptr_q] <= main_din;
  end

  // NOTE: every sequential register uses non-blocking assignment so all of them
  // update together from the same pre-edge values computed below.
  always_ff @(posedge phi0 or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_q       <= 8'h00;
      rsp_valid_q <= 1'b0;
      cmd_ovf_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      state_q     <= NMI_IDLE;
      timer_q     <= '0;
      ack_q       <= 1'b0;
      nmi_b_q     <= 1'b1;
      sndrst_b_q  <= 1'b0;
      rst_cnt_q   <= RW'(RST_CYCLES);
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ovf_q   <= cmd_ovf_d;
      rsp_ovf_q   <= rsp_ovf_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      nmi_b_q     <= nmi_b_d;
      sndrst_b_q  <= sndrst_b_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns every _d and no latch is inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q;
    cmd_ovf_d   = cmd_ovf_q;
    rsp_ovf_d   = rsp_ovf_q;
    state_d     = state_q;
    timer_d     = timer_q;
    ack_d       = ack_q;
    nmi_b_d     = nmi_b_q;
    sndrst_b_d  = sndrst_b_q;
    rst_cnt_d   = rst_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    if (main_clr)    begin cmd_ovf_d = 1'b0; rsp_ovf_d = 1'b0; end
    if (cmd_ovf_evt) cmd_ovf_d = 1'b1;
    if (rsp_ovf_evt) rsp_ovf_d = 1'b1;

    if (main_rd) rsp_valid_d = 1'b0;
    if (rsp_wr) begin
      rsp_d       = snd_rsp_din;
      rsp_valid_d = 1'b1;
    end

    if (run) begin
      unique case (state_q)
        NMI_IDLE: if (!empty) begin
          state_d = NMI_ASSERT;
          nmi_b_d = 1'b0;
          timer_d = TW'(NMI_WIDTH - 1);
          ack_d   = 1'b0;
        end
        NMI_ASSERT: begin
          if (snd_cmd_rd) ack_d = 1'b1;
          if (timer_q == '0) begin
            nmi_b_d = 1'b1;
            state_d = (ack_q || snd_cmd_rd) ? NMI_IDLE : NMI_WAIT;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
        NMI_WAIT: if (snd_cmd_rd) state_d = NMI_IDLE;
        default: state_d = NMI_IDLE;
      endcase
    end else begin
      if (rst_cnt_q <= RW'(1)) begin
        sndrst_b_d = 1'b1;
        rst_cnt_d  = '0;
      end else begin
        rst_cnt_d  = rst_cnt_q - RW'(1);
      end
    end

    // A sound reset request overrides everything on the sound side; overflow flags survive.
    if (main_snd_rst) begin
      sndrst_b_d  = 1'b0;
      rst_cnt_d   = RW'(RST_CYCLES);
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rsp_valid_d = 1'b0;
      state_d     = NMI_IDLE;
      nmi_b_d     = 1'b1;
      ack_d       = 1'b0;
    end
  end

  assign main_dout    = rsp_q;
  assign main_status  = {cmd_ovf_q, rsp_ovf_q, full, rsp_valid_q};
  assign snd_cmd_dout = empty ? 8'hFF : mem_q[rd_ptr_q];
  assign snd_status   = {!empty, rsp_valid_q};
  assign SNDNMI_b     = nmi_b_q;
  assign SNDRST_b     = sndrst_b_q;

endmodule
